// File: rtl/time_manager.sv
`default_nettype none
// ============================================================================
// Module   : time_manager
// Purpose  : Central emulated-time scheduler. Collects the next-edge time of
//            N_CLK gated-clock generators, finds the masked minimum in a
//            registered comparator tree and broadcasts it on time_next for
//            exactly one clk_sys cycle. Between issues time_next carries the
//            all-ones sentinel, which no generator ever matches.
// Ports    : clk_sys    - system clock
//            rst        - asynchronous reset, active-high
//            run        - scheduling enable
//            en_in      - per-generator participation mask
//            time_in    - packed generator times, slice k = generator k
//            time_stop  - end of emulation (must be below all-ones)
//            time_next  - broadcast time, all-ones when nothing is issued
//            time_valid - high in the single cycle a real time is broadcast
//            done       - minimum reached or passed time_stop
//            err        - sticky, an issued time went backwards
//            step_count - number of issue cycles, wraps
// Revision : 1.0 - initial release
// ============================================================================
module time_manager #(
  parameter int N_CLK      = 4,
  parameter int TIME_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                        clk_sys,
  input  logic                        rst,
  input  logic                        run,
  input  logic [N_CLK-1:0]            en_in,
  input  logic [N_CLK*TIME_WIDTH-1:0] time_in,
  input  logic [TIME_WIDTH-1:0]       time_stop,
  output logic [TIME_WIDTH-1:0]       time_next,
  output logic                        time_valid,
  output logic                        done,
  output logic                        err,
  output logic [CNT_WIDTH-1:0]        step_count
);

  localparam int                    NLEV      = $clog2(N_CLK);
  localparam int                    L_STAGES  = NLEV + 1;
  localparam int                    WAIT_W    = $clog2(L_STAGES + 1);
  localparam logic [WAIT_W-1:0]     WAIT_LOAD = WAIT_W'(L_STAGES);
  localparam logic [TIME_WIDTH-1:0] SENTINEL  = '1;

  // Number of live nodes on tree level lvl (level 0 = masked inputs).
  function automatic int lvl_cnt(input int lvl);
    int n;
    n = N_CLK;
    for (int i = 0; i < lvl; i++) begin
      n = (n + 1) / 2;
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Min tree. lvl_d is the combinational value of each node, lvl_q its
  // register. Levels 0..NLEV-1 are registered; the root (level NLEV) feeds the
  // FSM directly and is captured by the time_next register, which therefore
  // acts as the final pipeline stage. This keeps the min fresh: a time_in
  // change sampled by stage 0 reaches the issue register L edges later.
  // Dead nodes are tied to the sentinel so they never win a comparison.
  // ---------------------------------------------------------------------------
  logic [TIME_WIDTH-1:0] lvl_d [0:NLEV][0:N_CLK-1];
  logic [TIME_WIDTH-1:0] lvl_q [0:NLEV][0:N_CLK-1];
  logic [TIME_WIDTH-1:0] min_w;

  for (genvar j = 0; j <= NLEV; j++) begin : g_lvl
    for (genvar k = 0; k < N_CLK; k++) begin : g_node
      if (k >= lvl_cnt(j)) begin : g_unused
        assign lvl_d[j][k] = SENTINEL;
      end else if (j == 0) begin : g_in
        assign lvl_d[j][k] = en_in[k] ? time_in[k*TIME_WIDTH +: TIME_WIDTH] : SENTINEL;
      end else if (2*k + 1 < lvl_cnt(j-1)) begin : g_pair
        assign lvl_d[j][k] = (lvl_q[j-1][2*k] <= lvl_q[j-1][2*k+1]) ?
                             lvl_q[j-1][2*k] : lvl_q[j-1][2*k+1];
      end else begin : g_pass
        assign lvl_d[j][k] = lvl_q[j-1][2*k];
      end
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NLEV; j++) begin
        for (int k = 0; k < N_CLK; k++) begin
          lvl_q[j][k] <= SENTINEL;
        end
      end
    end else begin
      for (int j = 0; j < NLEV; j++) begin
        for (int k = 0; k < N_CLK; k++) begin
          lvl_q[j][k] <= lvl_d[j][k];
        end
      end
    end
  end

  assign min_w = lvl_d[NLEV][0];

  // ---------------------------------------------------------------------------
  // Scheduler FSM. All outputs are registered; issue bookkeeping (step count,
  // last issued time, backwards check) happens on the edge entering ISSUE so
  // it is visible during the broadcast cycle.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [TIME_WIDTH-1:0] time_next_q, time_next_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  step_q, step_d;
  logic [TIME_WIDTH-1:0] last_q, last_d;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= WAIT_LOAD;
      time_next_q <= SENTINEL;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      step_q      <= '0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      time_next_q <= time_next_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      step_q      <= step_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    time_next_d = SENTINEL;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    step_d      = step_q;
    last_d      = last_q;

    unique case (state_q)
      IDLE: begin
        wait_d = WAIT_LOAD;
        if (run) begin
          state_d = FILL;
        end
      end

      FILL: begin
        if (!run) begin
          state_d = IDLE;
        end else if (wait_q > WAIT_W'(1)) begin
          wait_d = wait_q - WAIT_W'(1);
        end else if (min_w == SENTINEL) begin
          // Every generator masked: keep waiting, nothing to issue.
          wait_d = WAIT_LOAD;
        end else if (min_w >= time_stop) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d     = ISSUE;
          time_next_d = min_w;
          valid_d     = 1'b1;
          step_d      = step_q + CNT_WIDTH'(1);
          last_d      = min_w;
          // last_q starts at zero, so the first issue can never flag.
          if (min_w < last_q) begin
            err_d = 1'b1;
          end
        end
      end

      ISSUE: begin
        wait_d  = WAIT_LOAD;
        state_d = run ? FILL : IDLE;
      end

      DONE: begin
        if (!run) begin
          state_d = IDLE;
        end else begin
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign time_next  = time_next_q;
  assign time_valid = valid_q;
  assign done       = done_q;
  assign err        = err_q;
  assign step_count = step_q;

endmodule
`default_nettype wire

// File: tb/tb_time_manager.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_manager
// Purpose  : Self-checking bench for time_manager (N_CLK=4, 32-bit times).
//            Table of directed vectors plus hand-written sequences for reset,
//            issue period, masking, mid-FILL reset and backwards-time error.
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_manager;

  localparam int          N    = 4;
  localparam int          TW   = 32;
  localparam int          CW   = 32;
  localparam int          L    = 3;
  localparam logic [31:0] SENT = 32'hFFFF_FFFF;

  logic             clk_sys = 1'b0;
  logic             rst;
  logic             run;
  logic [N-1:0]     en_in;
  logic [N*TW-1:0]  time_in;
  logic [TW-1:0]    time_stop;
  logic [TW-1:0]    time_next;
  logic             time_valid;
  logic             done;
  logic             err;
  logic [CW-1:0]    step_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_sys = ~clk_sys;

  time_manager #(
    .N_CLK      (N),
    .TIME_WIDTH (TW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .run        (run),
    .en_in      (en_in),
    .time_in    (time_in),
    .time_stop  (time_stop),
    .time_next  (time_next),
    .time_valid (time_valid),
    .done       (done),
    .err        (err),
    .step_count (step_count)
  );

  typedef struct {
    logic [3:0]   en;
    logic [127:0] tin;       // {t3, t2, t1, t0}
    logic [31:0]  stop;
    bit           exp_done;
    logic [31:0]  exp_next;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Step clk_sys until an issue or done appears, at most bound edges.
  // sent_ok drops if time_next leaves the sentinel while nothing is issued.
  task automatic wait_event(input int bound, output int cyc, output bit got_valid,
                            output bit got_done, output bit sent_ok);
    cyc       = 0;
    got_valid = 1'b0;
    got_done  = 1'b0;
    sent_ok   = 1'b1;
    while (!got_valid && !got_done && cyc < bound) begin
      @(posedge clk_sys);
      #1;
      cyc++;
      if (time_valid === 1'b1) got_valid = 1'b1;
      else if (done === 1'b1) got_done = 1'b1;
      else if (time_next !== SENT) sent_ok = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_time_next"}, time_next, SENT);
    chk({tag, "_valid"}, time_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_step"}, step_count, 0);
  endtask

  initial begin
    int      cyc;
    bit      gv, gd, so;
    int      exp_step;

    vecs[0] = '{en: 4'b1010, tin: {32'd8,   32'd5,   32'd9,   32'd3},          stop: 32'd100, exp_done: 1'b0, exp_next: 32'd8};
    vecs[1] = '{en: 4'b0001, tin: {32'd1,   32'd1,   32'd1,   32'd25},         stop: 32'd100, exp_done: 1'b0, exp_next: 32'd25};
    vecs[2] = '{en: 4'b1111, tin: {32'd99,  32'd41,  32'd40,  32'hFFFF_FFFE},  stop: 32'd100, exp_done: 1'b0, exp_next: 32'd40};
    vecs[3] = '{en: 4'b0110, tin: {32'd0,   32'd60,  32'd50,  32'd0},          stop: 32'd100, exp_done: 1'b0, exp_next: 32'd50};
    vecs[4] = '{en: 4'b1111, tin: {32'd400, 32'd300, 32'd200, 32'd99},         stop: 32'd100, exp_done: 1'b0, exp_next: 32'd99};
    vecs[5] = '{en: 4'b1111, tin: {32'd50,  32'd40,  32'd30,  32'd20},         stop: 32'd20,  exp_done: 1'b1, exp_next: SENT};
    vecs[6] = '{en: 4'b1111, tin: {32'd500, 32'd400, 32'd300, 32'd101},        stop: 32'd100, exp_done: 1'b1, exp_next: SENT};

    rst       = 1'b1;
    run       = 1'b0;
    en_in     = '0;
    time_in   = '0;
    time_stop = 32'd100;
    repeat (2) @(posedge clk_sys);
    #1;
    chk_reset_vals("reset");

    // Release reset with run high: first issue 1+L edges later.
    en_in   = 4'b1111;
    time_in = {32'd7, 32'd12, 32'd7, 32'd10};
    rst     = 1'b0;
    run     = 1'b1;
    wait_event(20, cyc, gv, gd, so);
    chk("first_latency", cyc, L + 1);
    chk("first_valid", gv, 1);
    chk("first_value", time_next, 32'd7);
    chk("first_step", step_count, 1);
    chk("first_sentinel_fill", so, 1);
    @(posedge clk_sys);
    #1;
    chk("single_cycle_valid", time_valid, 0);
    chk("sentinel_after_issue", time_next, SENT);
    wait_event(20, cyc, gv, gd, so);
    chk("issue_period", cyc + 1, L + 1);
    chk("second_value", time_next, 32'd7);
    chk("second_step", step_count, 2);
    chk("second_err", err, 0);
    exp_step = 2;
    run = 1'b0;
    @(posedge clk_sys);
    #1;
    chk("idle_after_run_drop", time_valid, 0);

    for (int i = 0; i < 7; i++) begin
      en_in     = vecs[i].en;
      time_in   = vecs[i].tin;
      time_stop = vecs[i].stop;
      run       = 1'b1;
      wait_event(20, cyc, gv, gd, so);
      if (!vecs[i].exp_done) exp_step++;
      chk($sformatf("vec%0d_latency", i), cyc, L + 1);
      chk($sformatf("vec%0d_done", i), gd, vecs[i].exp_done);
      chk($sformatf("vec%0d_valid", i), gv, !vecs[i].exp_done);
      chk($sformatf("vec%0d_time_next", i), time_next, vecs[i].exp_next);
      chk($sformatf("vec%0d_step", i), step_count, exp_step);
      chk($sformatf("vec%0d_err", i), err, 0);
      chk($sformatf("vec%0d_sentinel_fill", i), so, 1);
      if (vecs[i].exp_done) begin
        @(posedge clk_sys);
        #1;
        chk($sformatf("vec%0d_done_held", i), done, 1);
        chk($sformatf("vec%0d_done_no_issue", i), time_valid, 0);
      end
      run = 1'b0;
      @(posedge clk_sys);
      #1;
      chk($sformatf("vec%0d_idle_done", i), done, 0);
      chk($sformatf("vec%0d_idle_valid", i), time_valid, 0);
    end

    // Everything masked: no issue, step count frozen.
    en_in     = 4'b0000;
    time_in   = {4{32'd5}};
    time_stop = 32'd100;
    run       = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk_sys);
      #1;
      chk($sformatf("masked_valid_c%0d", c), time_valid, 0);
    end
    chk("masked_step", step_count, exp_step);
    en_in     = 4'b1111;
    time_in   = {4{32'd150}};
    time_stop = 32'd200;
    wait_event(12, cyc, gv, gd, so);
    exp_step++;
    chk("unmask_valid", gv, 1);
    chk("unmask_value", time_next, 32'd150);
    chk("unmask_step", step_count, exp_step);
    run = 1'b0;
    @(posedge clk_sys);
    #1;

    // Asynchronous reset in the middle of FILL.
    run = 1'b1;
    @(posedge clk_sys);
    #1;
    @(posedge clk_sys);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("midfill_reset");
    en_in     = 4'b1111;
    time_in   = {32'd90, 32'd80, 32'd70, 32'd15};
    time_stop = 32'd100;
    @(posedge clk_sys);
    #1;
    rst = 1'b0;
    wait_event(20, cyc, gv, gd, so);
    chk("rel_latency", cyc, L + 1);
    chk("rel_value", time_next, 32'd15);
    chk("rel_step", step_count, 1);
    chk("rel_err", err, 0);

    // Generator updates at the edge ending ISSUE; new min goes backwards.
    @(posedge clk_sys);
    #1;
    time_in = {32'd90, 32'd80, 32'd70, 32'd12};
    wait_event(20, cyc, gv, gd, so);
    chk("back_period", cyc + 1, L + 1);
    chk("back_value", time_next, 32'd12);
    chk("back_err", err, 1);
    chk("back_step", step_count, 2);
    @(posedge clk_sys);
    #1;
    time_in = {32'd90, 32'd80, 32'd70, 32'd30};
    wait_event(20, cyc, gv, gd, so);
    chk("sticky_value", time_next, 32'd30);
    chk("sticky_err", err, 1);
    chk("sticky_step", step_count, 3);
    run = 1'b0;
    @(posedge clk_sys);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
